// File: rtl/penc_seq.sv
// penc_seq: sequential priority encoder.
// Accepts a WIDTH-bit request vector over valid/ready. It then emits the index of
// every set bit, one beat per cycle, from the highest bit down. out_last marks the
// final beat of each vector.
// An all-zero vector produces a single beat with out_idx=0, out_zero=1, out_last=1.
//
// Optional feature (macro PENC_SEQ_CNT_EN): adds out_cnt, the popcount of the
// accepted vector, registered at acceptance.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   in_valid   in_vec is presented
//   in_ready   block can accept a vector this cycle (depends on out_ready)
//   in_vec     request vector, bit WIDTH-1 highest priority
//   out_valid  out_idx/out_last/out_zero are valid
//   out_ready  consumer takes the current beat
//   out_idx    index of the highest remaining set bit
//   out_last   current beat is the final beat of the vector
//   out_zero   accepted vector was all zeros
//   out_cnt    popcount of the accepted vector (PENC_SEQ_CNT_EN only)
//   busy       a vector is held
module penc_seq #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_last,
    output logic              out_zero,
`ifdef PENC_SEQ_CNT_EN
    output logic [IDXW:0]     out_cnt,
`endif
    output logic              busy
);

    localparam int unsigned CNTW = IDXW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic               zflag_q, zflag_d;
    logic [IDXW-1:0]    hi_idx;
    logic               single;
    logic               accept;

    // Highest set bit of pend; ascending scan so the top bit wins.
    always_comb begin
        hi_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pend_q[i]) hi_idx = IDXW'(i);
        end
    end

    // At most one bit left: this beat is the last of the vector.
    assign single = ((pend_q & (pend_q - WIDTH'(1))) == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zflag_q <= zflag_d;
        end
    end

    // Next-state and outputs; outputs are forced to 0 while no beat is valid.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        zflag_d   = zflag_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SCAN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_idx   = hi_idx;
                out_last  = single;
                out_zero  = zflag_q;
                in_ready  = single && out_ready;
                if (out_ready) begin
                    if (!single) begin
                        pend_d[hi_idx] = 1'b0;
                    end else begin
                        state_d = IDLE;
                        pend_d  = '0;
                        zflag_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new vector on the last beat overrides the return to IDLE.
        accept = in_valid && in_ready;
        if (accept) begin
            state_d = SCAN;
            pend_d  = in_vec;
            zflag_d = (in_vec == '0);
        end
    end

`ifdef PENC_SEQ_CNT_EN
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] vec_pop;

    // Popcount of the incoming vector.
    always_comb begin
        vec_pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            vec_pop = vec_pop + CNTW'(in_vec[i]);
        end
    end

    // Count captured at acceptance, held for all beats of the vector.
    always_ff @(posedge clk) begin
        if (rst)         cnt_q <= '0;
        else if (accept) cnt_q <= vec_pop;
    end

    assign out_cnt = cnt_q;
`endif

endmodule
